// File: rtl/serializador.sv
// Serializer: pops bytes from fila and shifts them out one bit per clk_10KHz cycle.
// Latency: first bit on serial_out right after the edge that sees len_in != 0 && ready_in.
// Backpressure: ready_in is sampled only between frames; a started frame always completes.
//
// Transmit side of the 1-bit serial link, mirror of the deserializer. Runs in
// the same 10 kHz domain as fila, so the dequeue handshake needs no CDC.
//
// Parameters:
//   DATA_W      payload width in bits (>= 2)
//   MSB_FIRST   1: bit DATA_W-1 goes first; 0: bit 0 goes first
//   GAP_CYCLES  idle cycles forced after each frame (1..15)
//
// Ports:
//   clk_10KHz    in   clock, rising edge
//   reset        in   asynchronous, active-high
//   len_in       in   fila occupancy, 0 = empty
//   data_in      in   fila head word, valid while len_in != 0
//   ready_in     in   sink can take a new frame
//   dequeue_out  out  one-cycle pop pulse to fila, coincides with the first bit
//   serial_out   out  serial data bit
//   write_out    out  high while serial_out carries a frame bit
//   busy_out     out  high whenever the FSM is not idle
//   frames_out   out  completed frame count, wraps 255 -> 0
//
// Build option: define SERIALIZADOR_PARITY_EN to append one even-parity bit
// (XOR of the payload) after the data bits, inside the write_out window.

module serializador #(
  parameter int DATA_W     = 8,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk_10KHz,
  input  logic              reset,
  input  logic [7:0]        len_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ready_in,
  output logic              dequeue_out,
  output logic              serial_out,
  output logic              write_out,
  output logic              busy_out,
  output logic [7:0]        frames_out
);

  localparam int              CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W);
  localparam logic [3:0]       GAP_LAST = 4'(GAP_CYCLES);

`ifdef SERIALIZADOR_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2, GAP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd3} state_t;
`endif

  // The bit currently on the wire is kept at the head of shreg; advancing
  // drops it and brings the next one to the head.
  function automatic logic head_bit(input logic [DATA_W-1:0] w);
    if (MSB_FIRST != 0) return w[DATA_W-1];
    else                return w[0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    if (MSB_FIRST != 0) return {w[DATA_W-2:0], 1'b0};
    else                return {1'b0, w[DATA_W-1:1]};
  endfunction

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]        gap_cnt_q, gap_cnt_d;
  logic [7:0]        frames_d;
  logic              deq_d, ser_d, wr_d, busy_d;
`ifdef SERIALIZADOR_PARITY_EN
  // Parity is taken from the word as loaded, since shreg is consumed while shifting.
  logic              par_q, par_d;
`endif
  logic              start, load, to_gap;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    frames_d  = frames_out;
    deq_d     = 1'b0;
    ser_d     = 1'b0;
    wr_d      = 1'b0;
`ifdef SERIALIZADOR_PARITY_EN
    par_d     = par_q;
`endif
    start     = (len_in != 8'd0) && ready_in;
    load      = 1'b0;
    to_gap    = 1'b0;

    case (state_q)
      IDLE: begin
        load = start;
      end
      SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
`ifdef SERIALIZADOR_PARITY_EN
          state_d = PARITY;
          ser_d   = par_q;
          wr_d    = 1'b1;
`else
          to_gap  = 1'b1;
`endif
        end else begin
          shreg_d   = advance(shreg_q);
          ser_d     = head_bit(advance(shreg_q));
          wr_d      = 1'b1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
`ifdef SERIALIZADOR_PARITY_EN
      PARITY: begin
        to_gap = 1'b1;
      end
`endif
      GAP: begin
        // The last gap cycle doubles as the idle decision, so a non-empty
        // fila gets back-to-back frames with exactly GAP_CYCLES between them.
        if (gap_cnt_q == GAP_LAST) begin
          load = start;
          if (!start) state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (to_gap) begin
      state_d   = GAP;
      gap_cnt_d = 4'd1;
      frames_d  = frames_out + 8'd1;
    end

    if (load) begin
      state_d   = SHIFT;
      shreg_d   = data_in;
      ser_d     = head_bit(data_in);
      wr_d      = 1'b1;
      deq_d     = 1'b1;
      bit_cnt_d = CNT_W'(1);
`ifdef SERIALIZADOR_PARITY_EN
      par_d     = ^data_in;
`endif
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
`ifdef SERIALIZADOR_PARITY_EN
      par_q       <= 1'b0;
`endif
      dequeue_out <= 1'b0;
      serial_out  <= 1'b0;
      write_out   <= 1'b0;
      busy_out    <= 1'b0;
      frames_out  <= 8'd0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
`ifdef SERIALIZADOR_PARITY_EN
      par_q       <= par_d;
`endif
      dequeue_out <= deq_d;
      serial_out  <= ser_d;
      write_out   <= wr_d;
      busy_out    <= busy_d;
      frames_out  <= frames_d;
    end
  end

endmodule

// File: tb/tb_serializador.sv
// Bench for serializador: two instances (MSB-first and LSB-first) share one
// fila model; each frame seen on the wire is rebuilt and compared with the
// popped byte, and frame start, dequeue, busy and frame count follow the
// link timing rules cycle by cycle.
`timescale 1ns/1ps
module tb_serializador;

  localparam int DATA_W     = 8;
  localparam int GAP_CYCLES = 1;
`ifdef SERIALIZADOR_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_LEN = DATA_W + PAR;

  logic       clk_10KHz = 1'b0;
  logic       reset     = 1'b0;
  logic       ready_in  = 1'b0;
  logic [7:0] len_in    = 8'd0;
  logic [7:0] data_in   = 8'd0;

  logic       deq0, ser0, wr0, busy0;
  logic [7:0] frm0;
  logic       deq1, ser1, wr1, busy1;
  logic [7:0] frm1;

  serializador #(.DATA_W(DATA_W), .MSB_FIRST(1), .GAP_CYCLES(GAP_CYCLES)) dut_msb (
    .clk_10KHz(clk_10KHz), .reset(reset), .len_in(len_in), .data_in(data_in),
    .ready_in(ready_in), .dequeue_out(deq0), .serial_out(ser0), .write_out(wr0),
    .busy_out(busy0), .frames_out(frm0));

  serializador #(.DATA_W(DATA_W), .MSB_FIRST(0), .GAP_CYCLES(GAP_CYCLES)) dut_lsb (
    .clk_10KHz(clk_10KHz), .reset(reset), .len_in(len_in), .data_in(data_in),
    .ready_in(ready_in), .dequeue_out(deq1), .serial_out(ser1), .write_out(wr1),
    .busy_out(busy1), .frames_out(frm1));

  always #5 clk_10KHz = ~clk_10KHz;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Model state
  logic [7:0] fq[$];
  int         cyc = 0;
  bit         in_frame[2];
  int         nbits[2];
  logic [8:0] got_bits[2];
  logic [7:0] cur_byte[2];
  int         next_ok[2];
  int         frames_model[2];
  int         st_q[$];
  logic [8:0] done_q[$];

  task automatic sync_fila();
    len_in  = 8'(fq.size());
    data_in = (fq.size() > 0) ? fq[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    sync_fila();
  endtask

  // Expected wire image: index 0 is the first bit sent, parity (if any) last.
  function automatic logic [8:0] frame_bits(input logic [7:0] b, input bit msb);
    logic [8:0] v = '0;
    for (int i = 0; i < 8; i++) v[i] = msb ? b[7-i] : b[i];
    if (PAR != 0) v[8] = ^b;
    return v;
  endfunction

  task automatic tick();
    bit         cond, start_exp, start_obs, busy_exp;
    logic [7:0] head;
    logic [1:0] wv, sv, dv, bv;
    logic [7:0] fv[2];
    cond = (len_in != 8'd0) && ready_in && !reset;
    @(negedge clk_10KHz);
    cyc++;
    wv = {wr1, wr0};  sv = {ser1, ser0};
    dv = {deq1, deq0}; bv = {busy1, busy0};
    fv[0] = frm0; fv[1] = frm1;
    head = data_in;
    if (dv[0] && fq.size() > 0) head = fq.pop_front();
    sync_fila();
    for (int k = 0; k < 2; k++) begin
      start_exp = cond && !in_frame[k] && (cyc >= next_ok[k]);
      start_obs = wv[k] && !in_frame[k];
      check($sformatf("start%0d@%0d", k, cyc), int'(start_obs), int'(start_exp));
      check($sformatf("dequeue%0d@%0d", k, cyc), int'(dv[k]), int'(start_exp));
      if (start_obs) begin
        in_frame[k] = 1'b1;
        nbits[k]    = 0;
        got_bits[k] = '0;
        cur_byte[k] = head;
        if (k == 0) st_q.push_back(cyc);
      end
      if (in_frame[k] && wv[k]) begin
        if (nbits[k] < 9) got_bits[k][nbits[k]] = sv[k];
        nbits[k]++;
      end else if (in_frame[k]) begin
        check($sformatf("frame_len%0d@%0d", k, cyc), nbits[k], FRAME_LEN);
        check($sformatf("frame_bits%0d@%0d", k, cyc), int'(got_bits[k]),
              int'(frame_bits(cur_byte[k], k == 0)));
        if (k == 0) done_q.push_back(got_bits[k]);
        in_frame[k] = 1'b0;
        frames_model[k]++;
        next_ok[k] = cyc + GAP_CYCLES;
      end
      if (!wv[k]) check($sformatf("serial_idle%0d@%0d", k, cyc), int'(sv[k]), 0);
      busy_exp = in_frame[k] || (cyc < next_ok[k]);
      check($sformatf("busy%0d@%0d", k, cyc), int'(bv[k]), int'(busy_exp));
      check($sformatf("frames%0d@%0d", k, cyc), int'(fv[k]), frames_model[k] % 256);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_write0", int'(wr0), 0);   check("rst_write1", int'(wr1), 0);
    check("rst_serial0", int'(ser0), 0); check("rst_serial1", int'(ser1), 0);
    check("rst_busy0", int'(busy0), 0);  check("rst_busy1", int'(busy1), 0);
    check("rst_deq0", int'(deq0), 0);    check("rst_deq1", int'(deq1), 0);
    check("rst_frames0", int'(frm0), 0); check("rst_frames1", int'(frm1), 0);
    for (int k = 0; k < 2; k++) begin
      in_frame[k] = 1'b0; nbits[k] = 0; next_ok[k] = 0; frames_model[k] = 0;
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((fq.size() != 0 || busy0 || busy1 || in_frame[0] || in_frame[1]) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, int'(n >= budget), 0);
  endtask

  task automatic wait_frames(input string tag, input int target, input int budget);
    int n = 0;
    while (frames_model[0] < target && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, int'(n >= budget), 0);
  endtask

  initial begin
    int c, n, pushed;

    #1;
    do_reset();

    // Empty fila, sink ready: nothing may happen.
    ready_in = 1'b1;
    repeat (50) tick();
    check("t1_frames", int'(frm0), 0);
    check("t1_busy", int'(busy0), 0);

    // Single byte A5.
    st_q.delete(); done_q.delete();
    push(8'hA5);
    c = cyc;
    wait_done("t2", 100);
    check("t2_frames", int'(frm0), 1);
    check("t2_latency", (st_q.size() > 0) ? st_q[0] : -1, c + 1);
    check("t2_wire_msb", (done_q.size() > 0) ? int'(done_q[0][7:0]) : -1, 8'hA5);

    // Three bytes back to back.
    st_q.delete();
    push(8'h01); push(8'h80); push(8'hFF);
    wait_done("t3", 200);
    check("t3_nframes", st_q.size(), 3);
    if (st_q.size() == 3) begin
      check("t3_period01", st_q[1] - st_q[0], FRAME_LEN + GAP_CYCLES);
      check("t3_period12", st_q[2] - st_q[1], FRAME_LEN + GAP_CYCLES);
    end
    check("t3_frames", int'(frm0), 4);

    // Sink not ready, then ready dropped mid-frame.
    ready_in = 1'b0;
    push(8'($urandom_range(0, 255)));
    push(8'($urandom_range(0, 255)));
    repeat (10) tick();
    check("t4_len_held", int'(len_in), 2);
    ready_in = 1'b1;
    st_q.delete();
    c = cyc;
    tick();
    check("t4_start_cycle", (st_q.size() > 0) ? st_q[0] : -1, c + 1);
    n = 0;
    while (nbits[0] < 3 && n < 20) begin tick(); n++; end
    ready_in = 1'b0;
    wait_frames("t4", 5, 50);
    repeat (5) tick();
    check("t4_len_after", int'(len_in), 1);
    check("t4_frames", int'(frm1), 5);
    ready_in = 1'b1;
    wait_done("t4_drain", 100);
    check("t4_frames_end", int'(frm0), 6);

    // Reset in the middle of a frame.
    push(8'($urandom_range(0, 255)));
    push(8'($urandom_range(0, 255)));
    n = 0;
    while (!(in_frame[0] && nbits[0] == 4) && n < 40) begin tick(); n++; end
    check("t5_reach_bit4", nbits[0], 4);
    do_reset();
    check("t5_len_after_reset", int'(len_in), 1);
    wait_done("t5", 100);
    check("t5_frames", int'(frm0), 1);

    // Parity vectors (also plain frames in the default build).
    done_q.delete();
    push(8'h07); push(8'h03);
    wait_done("t6", 100);
    check("t6_nframes", done_q.size(), 2);
    if (done_q.size() == 2) begin
      check("t6_wire07", int'(done_q[0]), (PAR != 0) ? 9'h1E0 : 9'h0E0);
      check("t6_wire03", int'(done_q[1]), 9'h0C0);
    end

    // Random traffic: exactly 256 frames from reset, counter must wrap to 0.
    do_reset();
    pushed = 0;
    n = 0;
    while (frames_model[0] < 256 && n < 10000) begin
      if (pushed < 256 && fq.size() < 4 && $urandom_range(0, 2) == 0) begin
        push(8'($urandom_range(0, 255)));
        pushed++;
      end
      ready_in = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    check("rand_frames_seen", frames_model[0], 256);
    check("rand_wrap0", int'(frm0), 0);
    check("rand_wrap1", int'(frm1), 0);
    ready_in = 1'b1;
    wait_done("rand_drain", 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
